// File: rtl/jpeg_rle_encoder.sv
// JPEG AC/DC run-length symbol encoder.
// Takes 64 zigzag-ordered quantized coefficients per block and produces
// {run, size, amp} symbols with DC, ZRL and EOB handling.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ACCEPT | normal intake, one coefficient per cycle when output is free
// ZRL    | emitting further ZRL symbols while run >= 16, intake stalled
// HELD   | emitting the held nonzero coefficient after its ZRLs
module jpeg_rle_encoder #(
  parameter int COEF_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_run,
  output logic [3:0]               out_size,
  output logic [10:0]              out_amp,
  output logic                     out_dc,
  output logic                     out_last
);

  typedef enum logic [1:0] {ACCEPT, ZRL, HELD} state_t;

  // Most negative code has no positive twin in category 11; fold it onto -(2^(W-1)-1).
  localparam logic signed [COEF_W-1:0] COEF_MIN   = {1'b1, {(COEF_W-1){1'b0}}};
  localparam logic signed [COEF_W-1:0] COEF_CLAMP = {1'b1, {(COEF_W-2){1'b0}}, 1'b1};

  state_t      state;
  logic [5:0]  index;
  logic [5:0]  run;
  logic [5:0]  run_sub;
  logic [3:0]  held_size;
  logic [10:0] held_amp;
  logic        held_last;

  logic                     out_free;
  logic                     accept;
  logic                     coef_zero;
  logic signed [COEF_W-1:0] coef_c;
  logic signed [COEF_W-1:0] amp_src;
  logic [COEF_W-1:0]        mag;
  logic [3:0]               size;
  logic [11:0]              mask;
  logic [10:0]              amp;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == ACCEPT) && out_free;
  assign accept   = in_valid && in_ready;
  assign run_sub  = run - 6'd16;

  // Magnitude category (bit length of |coef|) and JPEG amplitude bits.
  always_comb begin
    coef_c    = (in_coef == COEF_MIN) ? COEF_CLAMP : in_coef;
    coef_zero = (in_coef == '0);
    mag       = coef_c[COEF_W-1] ? (~coef_c + COEF_W'(1)) : coef_c;
    size      = '0;
    for (int i = 0; i < COEF_W; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    mask    = (12'd1 << size) - 12'd1;
    amp_src = coef_c[COEF_W-1] ? (coef_c - COEF_W'(1)) : coef_c;
    amp     = 11'(amp_src) & mask[10:0];
  end

  // Control FSM with index/run counters and the registered symbol output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      index     <= '0;
      run       <= '0;
      held_size <= '0;
      held_amp  <= '0;
      held_last <= 1'b0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_size  <= '0;
      out_amp   <= '0;
      out_dc    <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        ACCEPT: begin
          if (accept) begin
            index <= index + 6'd1;
            if (index == 6'd0) begin
              out_valid <= 1'b1;
              out_run   <= 4'd0;
              out_size  <= size;
              out_amp   <= amp;
              out_dc    <= 1'b1;
              out_last  <= 1'b0;
              run       <= '0;
            end else if (coef_zero) begin
              if (index == 6'd63) begin
                // End of block: any pending zero run collapses into EOB.
                out_valid <= 1'b1;
                out_run   <= 4'd0;
                out_size  <= 4'd0;
                out_amp   <= '0;
                out_dc    <= 1'b0;
                out_last  <= 1'b1;
                run       <= '0;
              end else begin
                run <= run + 6'd1;
              end
            end else if (run < 6'd16) begin
              out_valid <= 1'b1;
              out_run   <= run[3:0];
              out_size  <= size;
              out_amp   <= amp;
              out_dc    <= 1'b0;
              out_last  <= (index == 6'd63);
              run       <= '0;
            end else begin
              // Park the coefficient and start the ZRL sequence on this edge.
              held_size <= size;
              held_amp  <= amp;
              held_last <= (index == 6'd63);
              out_valid <= 1'b1;
              out_run   <= 4'd15;
              out_size  <= 4'd0;
              out_amp   <= '0;
              out_dc    <= 1'b0;
              out_last  <= 1'b0;
              run       <= run_sub;
              state     <= (run_sub >= 6'd16) ? ZRL : HELD;
            end
          end
        end
        ZRL: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_run   <= 4'd15;
            out_size  <= 4'd0;
            out_amp   <= '0;
            out_dc    <= 1'b0;
            out_last  <= 1'b0;
            run       <= run_sub;
            if (run_sub < 6'd16) state <= HELD;
          end
        end
        HELD: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_run   <= run[3:0];
            out_size  <= held_size;
            out_amp   <= held_amp;
            out_dc    <= 1'b0;
            out_last  <= held_last;
            run       <= '0;
            state     <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Self-checking bench for jpeg_rle_encoder: a block-level reference model
// fills a symbol queue as coefficients are driven; a monitor pops and compares
// every handed-off symbol and checks output stability during stalls.
module tb_jpeg_rle_encoder;
  localparam int W = 12;
  typedef logic signed [W-1:0] blk_t [64];
  typedef logic [20:0] sym_t;  // {run, size, amp, dc, last}

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [W-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_run;
  logic [3:0]        out_size;
  logic [10:0]       out_amp;
  logic              out_dc;
  logic              out_last;
  logic [20:0]       obs;

  sym_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   popped = 0;
  bit   rand_ready = 1'b0;
  bit   prev_stall = 1'b0;
  sym_t held_obs;
  sym_t e;

  always #5 clk = ~clk;

  jpeg_rle_encoder #(.COEF_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_run(out_run), .out_size(out_size), .out_amp(out_amp),
    .out_dc(out_dc), .out_last(out_last)
  );

  assign obs = {out_run, out_size, out_amp, out_dc, out_last};

  // Scoreboard monitor: inputs change at posedge+1, so negedge values hold until the next edge.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held_obs)
          $display("FAIL stall_hold: got valid=%b sym=%h, need valid=1 sym=%h", out_valid, obs, held_obs);
        else passed++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        popped++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_symbol: got run=%0d size=%0d amp=%h dc=%b last=%b, need none",
                   out_run, out_size, out_amp, out_dc, out_last);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e)
            $display("FAIL symbol: got run=%0d size=%0d amp=%h dc=%b last=%b, need run=%0d size=%0d amp=%h dc=%b last=%b",
                     out_run, out_size, out_amp, out_dc, out_last,
                     e[20:17], e[16:13], e[12:2], e[1], e[0]);
          else passed++;
        end
      end
      prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
      held_obs   = obs;
    end
  end

  function automatic sym_t mk(int run, int v, bit dc, bit last);
    int m, sz, amp;
    if (v == -2048) v = -2047;
    m  = (v < 0) ? -v : v;
    sz = 0;
    while ((1 << sz) <= m) sz++;
    amp = (v < 0) ? ((1 << sz) - 1 - m) : m;
    return {4'(run), 4'(sz), 11'(amp), dc, last};
  endfunction

  function automatic void model_push(blk_t c);
    int run = 0;
    for (int i = 0; i < 64; i++) begin
      int v = int'(c[i]);
      if (i == 0) exp_q.push_back(mk(0, v, 1'b1, 1'b0));
      else if (v == 0) begin
        if (i == 63) exp_q.push_back(mk(0, 0, 1'b0, 1'b1));
        else run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back(mk(15, 0, 1'b0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(mk(run, v, 1'b0, i == 63));
        run = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_coef(input logic signed [W-1:0] v, output int gaps);
    bit done = 1'b0;
    bit acc;
    gaps     = 0;
    in_valid = 1'b1;
    in_coef  = v;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) done = 1'b1;
      else gaps++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: got no accept in 200 cycles, need accept");
    end
  endtask

  task automatic send_block(input blk_t c, output int gap_first, output int gap_all);
    int g;
    model_push(c);
    gap_first = 0;
    gap_all   = 0;
    for (int i = 0; i < 64; i++) begin
      send_coef(c[i], g);
      if (i == 0) gap_first = g;
      gap_all += g;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() > 0; t++) tick();
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d symbols outstanding, need 0", exp_q.size());
    else passed++;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_run, out_size, out_amp, out_dc, out_last} !== 22'd0)
      $display("FAIL reset_outputs: got valid=%b sym=%h, need all zero", out_valid, obs);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, need 1", in_ready);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_dc_only();
    blk_t c; int gf, ga, p0;
    foreach (c[i]) c[i] = '0;
    c[0] = -12'sd3;
    p0 = popped;
    send_block(c, gf, ga);
    drain();
    checks++;
    if (popped - p0 != 2) $display("FAIL dc_only_count: got %0d symbols, need 2", popped - p0);
    else passed++;
  endtask

  task automatic test_zrl();
    blk_t c; int gf, ga;
    foreach (c[i]) c[i] = '0;
    c[0] = 12'sd5; c[1] = 12'sd1; c[19] = -12'sd1;
    send_block(c, gf, ga);
    drain();
  endtask

  task automatic test_all_ones();
    blk_t c; int gf, ga, p0;
    foreach (c[i]) c[i] = 12'sd1;
    p0 = popped;
    send_block(c, gf, ga);
    checks++;
    if (ga != 0) $display("FAIL ones_gaps: got %0d in_ready gaps, need 0", ga);
    else passed++;
    drain();
    checks++;
    if (popped - p0 != 64) $display("FAIL ones_count: got %0d symbols, need 64", popped - p0);
    else passed++;
  endtask

  task automatic test_late_ac();
    blk_t a, b; int gf, ga;
    foreach (a[i]) a[i] = '0;
    foreach (b[i]) b[i] = '0;
    a[0] = 12'sd2; a[63] = 12'sd7;
    send_block(a, gf, ga);
    send_block(b, gf, ga);
    checks++;
    if (gf != 3) $display("FAIL late_ac_stall: got %0d in_ready-low cycles, need 3", gf);
    else passed++;
    drain();
  endtask

  task automatic test_clamp();
    blk_t c; int gf, ga;
    foreach (c[i]) c[i] = '0;
    c[0] = -12'sd2048; c[1] = -12'sd2048; c[2] = 12'sd2047; c[3] = -12'sd2047;
    c[40] = 12'sd1024; c[63] = -12'sd2048;
    send_block(c, gf, ga);
    drain();
  endtask

  task automatic test_random_back_to_back();
    blk_t c0, c1; int gf, ga;
    foreach (c0[i]) c0[i] = ($urandom_range(0, 3) == 0) ? W'(int'($urandom_range(0, 4095)) - 2048) : '0;
    foreach (c1[i]) c1[i] = ($urandom_range(0, 4) == 0) ? W'(int'($urandom_range(0, 64)) - 32) : '0;
    c1[0] = '0;
    rand_ready = 1'b1;
    send_block(c0, gf, ga);
    send_block(c1, gf, ga);
    drain();
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_midblock();
    blk_t c; int g, v, gf, ga;
    rand_ready = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      v = int'($urandom_range(1, 300));
      if ($urandom_range(0, 1) == 1) v = -v;
      exp_q.push_back(mk(0, v, i == 0, 1'b0));
      send_coef(W'(v), g);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL async_reset: got out_valid=%b, need 0", out_valid);
    else passed++;
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b, need 1", in_ready);
    else passed++;
    foreach (c[i]) c[i] = ($urandom_range(0, 2) == 0) ? W'(int'($urandom_range(0, 200)) - 100) : '0;
    c[0] = 12'sd9;
    send_block(c, gf, ga);
    drain();
    rand_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, need finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
    test_reset();
    test_dc_only();
    test_zrl();
    test_all_ones();
    test_late_ac();
    test_clamp();
    test_random_back_to_back();
    test_reset_midblock();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_rle_encoder.md
JPEG_RLE_ENCODER -- requirements
Module: jpeg_rle_encoder

Interface
REQ-001 SHALL have parameter COEF_W, default 12, width of signed quantized coefficient input.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, coefficient present.
REQ-005 SHALL have port in_ready, output, 1, coefficient accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 SHALL have port in_coef, input, COEF_W, signed two's-complement coefficient, zigzag order, 64 per block.
REQ-007 SHALL have port out_valid, output, 1, symbol present.
REQ-008 SHALL have port out_ready, input, 1, symbol consumed when out_valid and out_ready are both high.
REQ-009 SHALL have port out_run, output, 4, zero-run length preceding the coefficient.
REQ-010 SHALL have port out_size, output, 4, JPEG magnitude category, 0..11.
REQ-011 SHALL have port out_amp, output, 11, JPEG amplitude bits, right-aligned, upper bits zero.
REQ-012 SHALL have port out_dc, output, 1, marks the DC symbol of index 0.
REQ-013 SHALL have port out_last, output, 1, marks the final symbol of a block.

Function
REQ-014 SHALL keep a 6-bit index counter of accepted coefficients; it increments per accept and wraps 63->0, starting a new block.
REQ-015 SHALL keep a 6-bit zero-run counter for AC zeros; it is cleared at index 0.
REQ-016 SHALL compute size as the bit length of |coef|; coef==0 gives size 0; -2048 SHALL be clamped to -2047 (size 11).
REQ-017 SHALL compute amp as coef[size-1:0] when coef>0, and as (coef-1)[size-1:0] when coef<0.
REQ-018 SHALL, for index 0, emit {run=0, size, amp, dc=1} regardless of value, including a zero value.
REQ-019 SHALL, for an AC zero (index 1..63), emit nothing and increment the zero-run counter.
REQ-020 SHALL, for a nonzero AC with run<16, emit {run, size, amp}, then clear run.
REQ-021 SHALL, for a nonzero AC with run>=16, hold the coefficient in an internal register, emit ZRL {run=15, size=0, amp=0} and subtract 16 from run, repeating while run>=16, then emit the held symbol.
REQ-022 SHALL, at index 63 with coefficient zero, emit EOB {run=0, size=0, amp=0, last=1}; pending ZRLs SHALL NOT be emitted.
REQ-023 SHALL, at index 63 with coefficient nonzero, set out_last on that symbol, emit no EOB, and still emit any required ZRLs first.
REQ-024 SHALL use FSM states ACCEPT (normal intake), ZRL (emitting ZRLs, in_ready=0), HELD (emitting held symbol, in_ready=0); ACCEPT->ZRL on nonzero AC with run>=16; ZRL->HELD when the post-emission run <16; HELD->ACCEPT on symbol handoff.
REQ-025 SHALL register outputs: a symbol appears on out_* exactly one cycle after the accepting edge when the output register is free.
REQ-026 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-027 SHALL drive in_ready = (state==ACCEPT) and (out_valid==0 or out_ready==1); it is combinational from out_ready.
REQ-028 SHALL sustain one coefficient per cycle with out_ready held high and no ZRLs.

Reset
REQ-029 SHALL, on rst=1, asynchronously set state=ACCEPT, index=0, run=0, out_valid=0, out_run=0, out_size=0, out_amp=0, out_dc=0, out_last=0; in_ready SHALL then follow REQ-027.
REQ-030 SHALL, on rst asserted mid-block, discard the partial block; the first accept after release SHALL be index 0 (DC).

Verification
REQ-031 SHALL cover DC=-3 followed by 63 zeros -> {dc=1, size=2, amp=0b00}, then EOB with last=1; total 2 symbols.
REQ-032 SHALL cover DC=5, AC1=1, AC2..AC18=0, AC19=-1, rest zero -> DC {0,3,0b101}; {0,1,1}; ZRL {15,0,0}; {1,1,0}; EOB.
REQ-033 SHALL cover a block of 64 nonzero values of 1 -> 64 symbols {run=0, size=1, amp=1}, last=1 on the 64th, no EOB, no in_ready gaps with out_ready=1.
REQ-034 SHALL cover AC1..AC62=0 and AC63=7 -> three ZRLs, then {run=14, size=3, amp=0b111, last=1}, with in_ready low for 3 cycles.
REQ-035 SHALL cover coefficient -2048 -> size=11, amp=0x000 (clamped to -2047).
REQ-036 SHALL cover out_ready random toggling plus rst asserted at index 30 -> out_* stable during stalls, out_valid=0 after reset, and the next accept produces dc=1.
